// File: rtl/cmd_dispatcher_if.sv
// Signal bundle between cmd_dispatcher and its neighbours: the command
// selector upstream, the sensor reader and uart_tx downstream.
// The master modport is the dispatcher's view. The slave modport is the
// view of the surrounding logic or testbench that drives the dispatcher.
interface cmd_dispatcher_if;
    logic [7:0]  i_Address;
    logic [7:0]  i_Request;
    logic        i_Done;
    logic        o_Sensor_Start;
    logic [7:0]  o_Sensor_Addr;
    logic        i_Sensor_Done;
    logic [15:0] i_Sensor_Data;
    logic        i_Sensor_Err;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        i_Tx_Done;
    logic        o_Busy;
    logic        o_Overrun;

    modport master (
        input  i_Address, i_Request, i_Done,
        output o_Sensor_Start, o_Sensor_Addr,
        input  i_Sensor_Done, i_Sensor_Data, i_Sensor_Err,
        output o_Tx_DV, o_Tx_Byte,
        input  i_Tx_Done,
        output o_Busy, o_Overrun
    );

    modport slave (
        output i_Address, i_Request, i_Done,
        input  o_Sensor_Start, o_Sensor_Addr,
        output i_Sensor_Done, i_Sensor_Data, i_Sensor_Err,
        input  o_Tx_DV, o_Tx_Byte,
        output i_Tx_Done,
        input  o_Busy, o_Overrun
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: serves one decoded (address, request) command at a time.
// It runs a bounded-time sensor read and then streams a fixed-length
// response frame to uart_tx, one byte per i_Tx_Done.
// Optional feature: define DISPATCH_ADDR_ECHO_EN to prefix every frame with
// the latched address. The frame is then 3 bytes instead of 2.
// All outputs are registered, so each one is 0 straight out of reset.
module cmd_dispatcher #(
    parameter int NUM_SENSORS    = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             i_Clock,
    input  logic             i_Rst,
    cmd_dispatcher_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SENSOR_REQ,
        SENSOR_WAIT,
        TX_LOAD,
        TX_WAIT
    } state_t;

`ifdef DISPATCH_ADDR_ECHO_EN
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif
    localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ADDR_LIMIT   = 32'(NUM_SENSORS);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  req_q, req_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  idx_q, idx_d;
    logic [25:0] cnt_q, cnt_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_dv_q, tx_dv_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        accept_cmd;
    logic [7:0]  frame_byte;

    // Register the FSM state, the latched command and response, and every output.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            addr_q    <= 8'h00;
            req_q     <= 8'h00;
            code_q    <= 8'h00;
            data_q    <= 8'h00;
            idx_q     <= 2'd0;
            cnt_q     <= 26'd0;
            tx_byte_q <= 8'h00;
            tx_dv_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            code_q    <= code_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic. It also covers command acceptance (including an
    // i_Done that lands on the final i_Tx_Done) and response building.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req_d      = req_q;
        code_d     = code_q;
        data_d     = data_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        accept_cmd = 1'b0;
        overrun_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_Done) begin
                    accept_cmd = 1'b1;
                end
            end
            CHECK: begin
                idx_d = 2'd0;
                if ({24'd0, addr_q} >= ADDR_LIMIT) begin
                    code_d  = 8'hFE;
                    data_d  = 8'h00;
                    state_d = TX_LOAD;
                end else if ((req_q < 8'h01) || (req_q > 8'h03)) begin
                    code_d  = 8'hFF;
                    data_d  = 8'h00;
                    state_d = TX_LOAD;
                end else begin
                    state_d = SENSOR_REQ;
                end
            end
            SENSOR_REQ: begin
                cnt_d   = 26'd0;
                state_d = SENSOR_WAIT;
            end
            SENSOR_WAIT: begin
                if (bus.i_Sensor_Done) begin
                    state_d = TX_LOAD;
                    if (bus.i_Sensor_Err) begin
                        code_d = 8'h1F;
                        data_d = 8'h00;
                    end else if (req_q == 8'h01) begin
                        code_d = 8'h07;
                        data_d = 8'h00;
                    end else if (req_q == 8'h02) begin
                        code_d = 8'h09;
                        data_d = bus.i_Sensor_Data[7:0];
                    end else begin
                        code_d = 8'h08;
                        data_d = bus.i_Sensor_Data[15:8];
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    code_d  = 8'h1F;
                    data_d  = 8'h00;
                    state_d = TX_LOAD;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            TX_LOAD: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.i_Tx_Done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        if (bus.i_Done) begin
                            accept_cmd = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = TX_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_cmd) begin
            addr_d  = bus.i_Address;
            req_d   = bus.i_Request;
            state_d = CHECK;
        end else if (bus.i_Done && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Select the frame byte for the next TX_LOAD and derive the registered outputs from the next state.
    always_comb begin
        frame_byte = 8'h00;
`ifdef DISPATCH_ADDR_ECHO_EN
        case (idx_d)
            2'd0:    frame_byte = addr_q;
            2'd1:    frame_byte = code_d;
            default: frame_byte = data_d;
        endcase
`else
        case (idx_d)
            2'd0:    frame_byte = code_d;
            default: frame_byte = data_d;
        endcase
`endif
        tx_byte_d = (state_d == TX_LOAD) ? frame_byte : tx_byte_q;
        tx_dv_d   = (state_d == TX_LOAD);
        start_d   = (state_d == SENSOR_REQ);
        busy_d    = (state_d != IDLE);
    end

    assign bus.o_Sensor_Start = start_q;
    assign bus.o_Sensor_Addr  = addr_q;
    assign bus.o_Tx_DV        = tx_dv_q;
    assign bus.o_Tx_Byte      = tx_byte_q;
    assign bus.o_Busy         = busy_q;
    assign bus.o_Overrun      = overrun_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed testbench for cmd_dispatcher. The sensor timeout is shortened
// to 100 cycles. Expected frames follow the DISPATCH_ADDR_ECHO_EN setting.
module tb_cmd_dispatcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] expBytes [3];
    int         expLen;
    int         waitCount;

    cmd_dispatcher_if bus ();

    cmd_dispatcher #(
        .NUM_SENSORS    (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_Clock (clk),
        .i_Rst   (rst),
        .bus     (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance one cycle. Inputs are driven and outputs sampled 1 unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse i_Done for one cycle with the given command. Returns in the CHECK cycle.
    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] req);
        bus.i_Address = addr;
        bus.i_Request = req;
        bus.i_Done    = 1'b1;
        cycle();
        bus.i_Done    = 1'b0;
        checkOutput("busy_in_check", bus.o_Busy, 1);
        checkOutput("no_overrun_on_accept", bus.o_Overrun, 0);
    endtask

    // Build the expected frame for a response code/data pair.
    task automatic buildFrame(input logic [7:0] addr, input logic [7:0] code, input logic [7:0] data);
`ifdef DISPATCH_ADDR_ECHO_EN
        expBytes[0] = addr;
        expBytes[1] = code;
        expBytes[2] = data;
        expLen      = 3;
`else
        expBytes[0] = code;
        expBytes[1] = data;
        expBytes[2] = 8'h00;
        expLen      = 2;
        if (addr == 8'hFF) expBytes[2] = 8'h00;
`endif
    endtask

    // A valid command must pulse o_Sensor_Start exactly 2 cycles after i_Done. Returns in the first SENSOR_WAIT cycle.
    task automatic startValid(input logic [7:0] addr, input logic [7:0] req);
        applyStimulus(addr, req);
        checkOutput("start_early", bus.o_Sensor_Start, 0);
        cycle();
        checkOutput("sensor_start", bus.o_Sensor_Start, 1);
        checkOutput("sensor_addr", bus.o_Sensor_Addr, {24'd0, addr});
        cycle();
        checkOutput("start_one_cycle", bus.o_Sensor_Start, 0);
    endtask

    // Pulse i_Sensor_Done. Returns in the cycle where o_Tx_DV must be high.
    task automatic sensorReply(input logic [15:0] data, input logic err);
        bus.i_Sensor_Data = data;
        bus.i_Sensor_Err  = err;
        bus.i_Sensor_Done = 1'b1;
        cycle();
        bus.i_Sensor_Done = 1'b0;
        bus.i_Sensor_Err  = 1'b0;
    endtask

    // Walk the expected frame byte by byte, acknowledging each byte with i_Tx_Done.
    // It can also probe overrun or a late sensor pulse on byte 0, or chain a new command onto the last i_Tx_Done.
    task automatic serveFrame(input bit probeOverrun, input bit lateSensor,
                              input bit chainEn, input logic [7:0] chainAddr, input logic [7:0] chainReq);
        for (int i = 0; i < expLen; i++) begin
            checkOutput("tx_dv", bus.o_Tx_DV, 1);
            checkOutput("tx_byte", bus.o_Tx_Byte, {24'd0, expBytes[i]});
            cycle();
            checkOutput("tx_dv_one_cycle", bus.o_Tx_DV, 0);
            if (i == 0 && probeOverrun) begin
                bus.i_Address = 8'h09;
                bus.i_Request = 8'h02;
                bus.i_Done    = 1'b1;
                cycle();
                bus.i_Done    = 1'b0;
                checkOutput("overrun_pulse", bus.o_Overrun, 1);
                cycle();
                checkOutput("overrun_clears", bus.o_Overrun, 0);
            end else if (i == 0 && lateSensor) begin
                bus.i_Sensor_Data = 16'h5555;
                bus.i_Sensor_Done = 1'b1;
                cycle();
                bus.i_Sensor_Done = 1'b0;
                checkOutput("late_sensor_no_dv", bus.o_Tx_DV, 0);
            end else begin
                cycle();
            end
            checkOutput("tx_byte_held", bus.o_Tx_Byte, {24'd0, expBytes[i]});
            checkOutput("busy_in_tx_wait", bus.o_Busy, 1);
            if (i == expLen - 1 && chainEn) begin
                bus.i_Address = chainAddr;
                bus.i_Request = chainReq;
                bus.i_Done    = 1'b1;
            end
            bus.i_Tx_Done = 1'b1;
            cycle();
            bus.i_Tx_Done = 1'b0;
            bus.i_Done    = 1'b0;
        end
        if (chainEn) begin
            checkOutput("chain_busy", bus.o_Busy, 1);
            checkOutput("chain_no_overrun", bus.o_Overrun, 0);
            checkOutput("chain_addr", bus.o_Sensor_Addr, {24'd0, chainAddr});
        end else begin
            checkOutput("busy_low_after_frame", bus.o_Busy, 0);
        end
    endtask

    // Invalid command: no sensor start, first o_Tx_DV 2 cycles after i_Done.
    task automatic invalidCmd(input logic [7:0] addr, input logic [7:0] req, input logic [7:0] code);
        applyStimulus(addr, req);
        checkOutput("invalid_no_start_a", bus.o_Sensor_Start, 0);
        cycle();
        checkOutput("invalid_no_start_b", bus.o_Sensor_Start, 0);
        checkOutput("invalid_addr_latched", bus.o_Sensor_Addr, {24'd0, addr});
        buildFrame(addr, code, 8'h00);
        serveFrame(0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        bus.i_Address     = 8'h00;
        bus.i_Request     = 8'h00;
        bus.i_Done        = 1'b0;
        bus.i_Sensor_Done = 1'b0;
        bus.i_Sensor_Data = 16'h0000;
        bus.i_Sensor_Err  = 1'b0;
        bus.i_Tx_Done     = 1'b0;

        // Reset values.
        cycle();
        cycle();
        checkOutput("rst_busy", bus.o_Busy, 0);
        checkOutput("rst_tx_dv", bus.o_Tx_DV, 0);
        checkOutput("rst_tx_byte", bus.o_Tx_Byte, 0);
        checkOutput("rst_start", bus.o_Sensor_Start, 0);
        checkOutput("rst_sensor_addr", bus.o_Sensor_Addr, 0);
        checkOutput("rst_overrun", bus.o_Overrun, 0);
        rst = 1'b0;
        cycle();

        // Temperature read, addr 0x05, data 0x3A19 -> 0x09, 0x19.
        startValid(8'h05, 8'h02);
        cycle();
        cycle();
        checkOutput("addr_held_in_wait", bus.o_Sensor_Addr, 32'h05);
        sensorReply(16'h3A19, 1'b0);
        buildFrame(8'h05, 8'h09, 8'h19);
        serveFrame(0, 0, 0, 8'h00, 8'h00);

        // Humidity read with sensor error -> 0x1F, 0x00.
        startValid(8'h05, 8'h03);
        sensorReply(16'h3A19, 1'b1);
        buildFrame(8'h05, 8'h1F, 8'h00);
        serveFrame(0, 0, 0, 8'h00, 8'h00);

        // Humidity read ok at the top valid address -> 0x08, 0x3A.
        startValid(8'h1F, 8'h03);
        sensorReply(16'h3A19, 1'b0);
        buildFrame(8'h1F, 8'h08, 8'h3A);
        serveFrame(0, 0, 0, 8'h00, 8'h00);

        // Status ok -> 0x07, 0x00.
        startValid(8'h02, 8'h01);
        sensorReply(16'hBEEF, 1'b0);
        buildFrame(8'h02, 8'h07, 8'h00);
        serveFrame(0, 0, 0, 8'h00, 8'h00);

        // Invalid address, invalid code, and address priority over code.
        invalidCmd(8'h20, 8'h02, 8'hFE);
        invalidCmd(8'h01, 8'h07, 8'hFF);
        invalidCmd(8'h20, 8'h07, 8'hFE);
        invalidCmd(8'h02, 8'h00, 8'hFF);

        // Timeout: first o_Tx_DV exactly 101 cycles after o_Sensor_Start. A late sensor pulse is ignored.
        startValid(8'h04, 8'h02);
        waitCount = 1;
        while (bus.o_Tx_DV !== 1'b1 && waitCount < 300) begin
            cycle();
            waitCount++;
        end
        checkOutput("timeout_latency", waitCount, 101);
        buildFrame(8'h04, 8'h1F, 8'h00);
        serveFrame(0, 1, 0, 8'h00, 8'h00);

        // Overrun during TX_WAIT. The frame is unchanged and the next command is chained onto the last i_Tx_Done.
        startValid(8'h05, 8'h02);
        sensorReply(16'h3A19, 1'b0);
        buildFrame(8'h05, 8'h09, 8'h19);
        serveFrame(1, 0, 1, 8'h03, 8'h02);
        cycle();
        checkOutput("chain_start", bus.o_Sensor_Start, 1);
        cycle();
        sensorReply(16'h0042, 1'b0);
        buildFrame(8'h03, 8'h09, 8'h42);
        serveFrame(0, 0, 0, 8'h00, 8'h00);

        // Reset asserted mid-SENSOR_WAIT, then a normal command.
        startValid(8'h06, 8'h02);
        cycle();
        rst = 1'b1;
        cycle();
        checkOutput("midrst_busy", bus.o_Busy, 0);
        checkOutput("midrst_tx_dv", bus.o_Tx_DV, 0);
        checkOutput("midrst_tx_byte", bus.o_Tx_Byte, 0);
        checkOutput("midrst_start", bus.o_Sensor_Start, 0);
        checkOutput("midrst_sensor_addr", bus.o_Sensor_Addr, 0);
        rst = 1'b0;
        cycle();
        startValid(8'h03, 8'h02);
        sensorReply(16'h2B17, 1'b0);
        buildFrame(8'h03, 8'h09, 8'h17);
        serveFrame(0, 0, 0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Consumes the decoded command pair from the UART command selector and serves it. Performs a bounded-time sensor transaction, then streams a fixed-length response frame to the UART transmitter. Sits between the selector (upstream, `address`/`request`/`done`) and the sensor reader plus `uart_tx` (downstream). Processes one command at a time; commands arriving while busy are dropped and flagged.

## Interface
Parameters:
- `NUM_SENSORS`, 32: valid addresses are 0 to NUM_SENSORS-1.
- `TIMEOUT_CYCLES`, 50_000_000: maximum cycles to wait for sensor completion (1 s at 50 MHz).

Ports:
- `i_Clock` in 1: sole clock; all logic on rising edge.
- `i_Rst` in 1: asynchronous, active-high reset.
- `i_Address` in 8: sensor address from the selector.
- `i_Request` in 8: request code from the selector.
- `i_Done` in 1: one-cycle pulse; `i_Address` and `i_Request` are valid in that cycle.
- `o_Sensor_Start` out 1: one-cycle pulse that starts a sensor read.
- `o_Sensor_Addr` out 8: latched address; held stable from start until the read ends.
- `i_Sensor_Done` in 1: one-cycle pulse; data and error flag are valid in that cycle.
- `i_Sensor_Data` in 16: bits [15:8] are humidity integer; bits [7:0] are temperature integer.
- `i_Sensor_Err` in 1: checksum or protocol failure; qualified by `i_Sensor_Done`.
- `o_Tx_DV` out 1: one-cycle pulse that loads `o_Tx_Byte` into `uart_tx`.
- `o_Tx_Byte` out 8: byte to transmit.
- `i_Tx_Done` in 1: one-cycle pulse when `uart_tx` finishes the stop bit.
- `o_Busy` out 1: high in every state except IDLE.
- `o_Overrun` out 1: one-cycle pulse when `i_Done` arrives while busy.

## Operation
Request codes:
- 0x01: status. Response is 0x07,0x00 if the sensor is ok, 0x1F,0x00 on error.
- 0x02: temperature. Response is 0x09, then temperature.
- 0x03: humidity. Response is 0x08, then humidity.
- Any other code: response 0xFF,0x00. No sensor access.
- Address ≥ NUM_SENSORS: response 0xFE,0x00. No sensor access. The address check takes priority over the request-code check.

Sensor failure:
- Sensor error or timeout on requests 0x01–0x03 produces 0x1F,0x00.

State machine:
- IDLE: on `i_Done`, latch address and request, go to CHECK.
- CHECK: for invalid input, load the response and go to TX_LOAD. Otherwise go to SENSOR_REQ.
- SENSOR_REQ: pulse `o_Sensor_Start`, clear the timeout counter, go to SENSOR_WAIT.
- SENSOR_WAIT:
  - On `i_Sensor_Done`, build the response and go to TX_LOAD.
  - When the counter reaches TIMEOUT_CYCLES-1, build the 0x1F response and go to TX_LOAD.
  - If done and timeout occur in the same cycle, done wins.
- TX_LOAD: drive `o_Tx_Byte` with the current frame byte, pulse `o_Tx_DV`, go to TX_WAIT.
- TX_WAIT: on `i_Tx_Done`, advance the byte index. Return to TX_LOAD if bytes remain; otherwise go to IDLE.

Other rules:
- Timeout counter: 26-bit, saturating; it does not wrap.
- Sensor and TX pulses arriving in states that do not expect them are ignored.
- Reset mid-operation: returns to IDLE immediately. No partial frame is resumed; the transmitter finishes any byte already loaded on its own.

## Timing
Reset values:
- All outputs 0, state IDLE, latched address/request 0x00, counter 0.

Latencies:
- `i_Done` to `o_Sensor_Start`: 2 cycles (IDLE→CHECK→SENSOR_REQ).
- `i_Done` to first `o_Tx_DV` for an invalid command: 2 cycles.
- `i_Sensor_Done` to first `o_Tx_DV`: 1 cycle.
- `i_Tx_Done` to next `o_Tx_DV`: 1 cycle.
- Last `i_Tx_Done` to `o_Busy` low: 1 cycle.

Handshake and holding:
- `i_Done` in the same cycle the FSM returns to IDLE is accepted, with no overrun.
- `o_Tx_Byte` holds its value from TX_LOAD until the next TX_LOAD.
- `o_Sensor_Addr` holds the latched address until the next accepted command.
- `o_Overrun` is asserted the cycle after the offending `i_Done`.

## Configuration
- `DISPATCH_ADDR_ECHO_EN` defined: the frame is 3 bytes (latched address, code, data). This applies to every response, including 0xFE and 0xFF.
- Undefined: the frame is 2 bytes (code, data).

## Test plan
- Reset asserted mid-SENSOR_WAIT: next cycle `o_Busy`=0 and all outputs 0. A following `i_Done` (addr 0x03, req 0x02) is served normally.
- addr 0x05, req 0x02; sensor returns data 0x3A19, err 0: `o_Sensor_Addr`=0x05, TX sends 0x09, 0x19 (with echo: 0x05, 0x09, 0x19). Each byte waits for `i_Tx_Done`.
- addr 0x05, req 0x03, err=1: TX sends 0x1F, 0x00. Addr 0x20 with any request: 0xFE, 0x00, no sensor start. addr 0x01, req 0x07: 0xFF, 0x00.
- `TIMEOUT_CYCLES`=100, sensor never responds: 0x1F response, first `o_Tx_DV` exactly 101 cycles after `o_Sensor_Start`. A late `i_Sensor_Done` is ignored.
- Second `i_Done` during TX_WAIT: `o_Overrun` pulse, first frame unchanged. `i_Done` coinciding with the return to IDLE is accepted with no overrun.
